// File: rtl/issue_0110011_if.sv
`default_nettype none
// ============================================================================
// Module      : issue_0110011_if
// Description : Instruction handshake, ALU issue and writeback bundle for the
//               R-type operand-issue stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface issue_0110011_if #(
  parameter int XLEN = 32
) ();
  // Upstream instruction handshake
  logic            instr_valid;
  logic [31:0]     instr;
  logic            instr_ready;
  // Issue towards the ALU
  logic            alu_valid;
  logic [6:0]      alu_funct7;
  logic [2:0]      alu_funct3;
  logic [XLEN-1:0] alu_rs1;
  logic [XLEN-1:0] alu_rs2;
  logic [4:0]      alu_rd;
  logic            illegal;
  // Writeback into the register file
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_value;

  // Environment side: supplies instructions and writebacks, observes issue
  modport master (
    output instr_valid, instr, wb_valid, wb_rd, wb_value,
    input  instr_ready, alu_valid, alu_funct7, alu_funct3, alu_rs1, alu_rs2,
           alu_rd, illegal
  );

  // Issue stage side
  modport slave (
    input  instr_valid, instr, wb_valid, wb_rd, wb_value,
    output instr_ready, alu_valid, alu_funct7, alu_funct3, alu_rs1, alu_rs2,
           alu_rd, illegal
  );
endinterface
`default_nettype wire

// File: rtl/issue_0110011.sv
`default_nettype none
// ============================================================================
// Module      : issue_0110011
// Description : Operand-issue stage for R-type ALU ops. Decodes, checks
//               legality, stalls on pending-register hazards, reads the
//               register file (with writeback bypass) and issues a registered
//               one-cycle pulse to the ALU. Owns the regfile write port.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_0110011 #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  issue_0110011_if.slave bus
);

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [2:0] F3_ADDSUB = 3'd0;
  localparam logic [2:0] F3_SR     = 3'd5;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]  regfile_q [NREGS];
  logic [XLEN-1:0]  regfile_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  logic             alu_valid_q, alu_valid_d;
  logic             illegal_q, illegal_d;
  logic [6:0]       alu_funct7_q, alu_funct7_d;
  logic [2:0]       alu_funct3_q, alu_funct3_d;
  logic [4:0]       alu_rd_q, alu_rd_d;
  logic [XLEN-1:0]  alu_rs1_q, alu_rs1_d;
  logic [XLEN-1:0]  alu_rs2_q, alu_rs2_d;

  // --------------------------------------------------------------------------
  // Decode
  // --------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [4:0] rd_idx, rs1_idx, rs2_idx;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode  = bus.instr[6:0];
  assign rd_idx  = bus.instr[11:7];
  assign funct3  = bus.instr[14:12];
  assign rs1_idx = bus.instr[19:15];
  assign rs2_idx = bus.instr[24:20];
  assign funct7  = bus.instr[31:25];

  // Only the base R-type encodings plus SUB/SRA are accepted
  always_comb begin
    legal = 1'b0;
    if (opcode == OPCODE_OP) begin
      if (funct7 == F7_BASE) begin
        legal = 1'b1;
      end else if (funct7 == F7_ALT &&
                   (funct3 == F3_ADDSUB || funct3 == F3_SR)) begin
        legal = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Writeback and hazard detection
  // --------------------------------------------------------------------------
  logic             wb_hit;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] pend_live;
  logic             hazard;
  logic             accept;

  // x0 is never written, so a writeback aimed at it is a no-op
  assign wb_hit = bus.wb_valid && (bus.wb_rd != 5'd0);

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_wb_clr
    assign wb_clr[gi] = wb_hit && (bus.wb_rd == 5'(gi));
  end

  // A register whose writeback lands this cycle is already resolved
  assign pend_live = pend_q & ~wb_clr;

  // Any live pending source or destination (x0 excluded) blocks a legal op
  always_comb begin
    hazard = 1'b0;
    if (rs1_idx != 5'd0 && pend_live[rs1_idx]) hazard = 1'b1;
    if (rs2_idx != 5'd0 && pend_live[rs2_idx]) hazard = 1'b1;
    if (rd_idx  != 5'd0 && pend_live[rd_idx])  hazard = 1'b1;
  end

  // Illegal ops never stall; they are consumed and flagged instead
  assign bus.instr_ready = rst_n && !(legal && hazard);
  assign accept          = bus.instr_valid && bus.instr_ready;

  // --------------------------------------------------------------------------
  // Operand read with writeback bypass
  // --------------------------------------------------------------------------
  logic [XLEN-1:0] rs1_val, rs2_val;

  // Bypass the in-flight writeback so a just-unstalled op sees fresh data
  always_comb begin
    rs1_val = regfile_q[rs1_idx];
    if (wb_hit && bus.wb_rd == rs1_idx) rs1_val = bus.wb_value;
    if (rs1_idx == 5'd0)                rs1_val = '0;
    rs2_val = regfile_q[rs2_idx];
    if (wb_hit && bus.wb_rd == rs2_idx) rs2_val = bus.wb_value;
    if (rs2_idx == 5'd0)                rs2_val = '0;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------

  // Regfile write port driven only by writeback
  always_comb begin
    regfile_d = regfile_q;
    if (wb_hit) regfile_d[bus.wb_rd] = bus.wb_value;
  end

  // Writeback clears, issue sets; the set is applied last so it wins
  always_comb begin
    pend_d = pend_q & ~wb_clr;
    if (accept && legal && rd_idx != 5'd0) pend_d[rd_idx] = 1'b1;
    pend_d[0] = 1'b0;
  end

  // Pulses last one cycle; ALU data fields only move on a legal issue
  always_comb begin
    alu_valid_d  = accept && legal;
    illegal_d    = accept && !legal;
    alu_funct7_d = alu_funct7_q;
    alu_funct3_d = alu_funct3_q;
    alu_rd_d     = alu_rd_q;
    alu_rs1_d    = alu_rs1_q;
    alu_rs2_d    = alu_rs2_q;
    if (accept && legal) begin
      alu_funct7_d = funct7;
      alu_funct3_d = funct3;
      alu_rd_d     = rd_idx;
      alu_rs1_d    = rs1_val;
      alu_rs2_d    = rs2_val;
    end
  end

  // Register update with synchronous active-low reset of all state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regfile_q[i] <= '0;
      pend_q       <= '0;
      alu_valid_q  <= 1'b0;
      illegal_q    <= 1'b0;
      alu_funct7_q <= '0;
      alu_funct3_q <= '0;
      alu_rd_q     <= '0;
      alu_rs1_q    <= '0;
      alu_rs2_q    <= '0;
    end else begin
      regfile_q    <= regfile_d;
      pend_q       <= pend_d;
      alu_valid_q  <= alu_valid_d;
      illegal_q    <= illegal_d;
      alu_funct7_q <= alu_funct7_d;
      alu_funct3_q <= alu_funct3_d;
      alu_rd_q     <= alu_rd_d;
      alu_rs1_q    <= alu_rs1_d;
      alu_rs2_q    <= alu_rs2_d;
    end
  end

  assign bus.alu_valid  = alu_valid_q;
  assign bus.illegal    = illegal_q;
  assign bus.alu_funct7 = alu_funct7_q;
  assign bus.alu_funct3 = alu_funct3_q;
  assign bus.alu_rd     = alu_rd_q;
  assign bus.alu_rs1    = alu_rs1_q;
  assign bus.alu_rs2    = alu_rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_issue_0110011.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_0110011
// Description : Self-checking bench for issue_0110011: directed scenarios
//               followed by randomized traffic, with a reference model and a
//               queue-based scoreboard checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_0110011;

  typedef struct {
    bit          ill;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    int          stamp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;

  issue_0110011_if #(.XLEN(32)) bus ();

  issue_0110011 #(.XLEN(32), .NREGS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [31:0] regs_m [32];
  bit          pend_m [32];
  exp_t        sb [$];
  exp_t        hold_m;

  // ---------------------------------------------------------------- model
  function automatic bit is_legal(input logic [31:0] i);
    if (i[6:0] != 7'h33) return 1'b0;
    if (i[31:25] == 7'h00) return 1'b1;
    return (i[31:25] == 7'h20) && (i[14:12] == 3'd0 || i[14:12] == 3'd5);
  endfunction

  function automatic logic [31:0] rd_op(input logic [4:0] idx, input bit wv,
                                        input logic [4:0] wrd, input logic [31:0] wval);
    if (idx == 0) return 32'h0;
    if (wv && wrd == idx) return wval;
    return regs_m[idx];
  endfunction

  function automatic bit busy(input logic [4:0] idx, input bit wv, input logic [4:0] wrd);
    return (idx != 0) && pend_m[idx] && !(wv && wrd == idx);
  endfunction

  // One clock cycle: drive inputs, check ready, advance the model
  task automatic step(input bit rstn, input bit v, input logic [31:0] ins,
                      input bit wv, input logic [4:0] wrd, input logic [31:0] wval,
                      output bit rdy);
    bit   lg, hz;
    exp_t e;
    @(posedge clk);
    #2;
    rst_n           = rstn;
    bus.instr_valid = v;
    bus.instr       = ins;
    bus.wb_valid    = wv;
    bus.wb_rd       = wrd;
    bus.wb_value    = wval;
    #1;
    lg  = is_legal(ins);
    hz  = busy(ins[19:15], wv, wrd) || busy(ins[24:20], wv, wrd) || busy(ins[11:7], wv, wrd);
    rdy = rstn && !(lg && hz);
    n_cmp++;
    if (bus.instr_ready !== rdy) begin
      n_fail++;
      $display("FAIL instr_ready cyc=%0d instr=%h got=%b exp=%b", cyc, ins, bus.instr_ready, rdy);
    end
    if (!rstn) begin
      for (int i = 0; i < 32; i++) begin regs_m[i] = 0; pend_m[i] = 0; end
    end else begin
      if (v && rdy) begin
        e.ill   = !lg;
        e.f7    = ins[31:25];
        e.f3    = ins[14:12];
        e.rd    = ins[11:7];
        e.a     = rd_op(ins[19:15], wv, wrd, wval);
        e.b     = rd_op(ins[24:20], wv, wrd, wval);
        e.stamp = cyc;
        sb.push_back(e);
      end
      if (wv && wrd != 0) begin regs_m[wrd] = wval; pend_m[wrd] = 0; end
      if (v && rdy && lg && ins[11:7] != 0) pend_m[ins[11:7]] = 1;
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    bit r;
    step(1, 1, ins, 0, 0, 0, r);
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] val);
    bit r;
    step(1, 0, 32'h0, 1, rd, val, r);
  endtask

  task automatic drain();
    for (int i = 1; i < 32; i++) if (pend_m[i]) wb(5'(i), $urandom());
  endtask

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) if (!rst_n) hold_m = '{default: 0};

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].stamp == cyc - 1) begin
        e = sb.pop_front();
        if (e.ill) begin
          ok = (bus.illegal === 1'b1) && (bus.alu_valid === 1'b0) &&
               (bus.alu_funct7 === hold_m.f7) && (bus.alu_funct3 === hold_m.f3) &&
               (bus.alu_rd === hold_m.rd) && (bus.alu_rs1 === hold_m.a) && (bus.alu_rs2 === hold_m.b);
        end else begin
          ok = (bus.alu_valid === 1'b1) && (bus.illegal === 1'b0) &&
               (bus.alu_funct7 === e.f7) && (bus.alu_funct3 === e.f3) &&
               (bus.alu_rd === e.rd) && (bus.alu_rs1 === e.a) && (bus.alu_rs2 === e.b);
          hold_m = e;
        end
        n_cmp++;
        if (!ok) begin
          n_fail++;
          $display("FAIL issue cyc=%0d got v=%b ill=%b f7=%h f3=%h rd=%0d rs1=%h rs2=%h exp ill=%b f7=%h f3=%h rd=%0d rs1=%h rs2=%h",
                   cyc, bus.alu_valid, bus.illegal, bus.alu_funct7, bus.alu_funct3, bus.alu_rd,
                   bus.alu_rs1, bus.alu_rs2, e.ill, e.f7, e.f3, e.rd, e.a, e.b);
        end
      end else begin
        ok = (bus.alu_valid === 1'b0) && (bus.illegal === 1'b0) &&
             (bus.alu_funct7 === hold_m.f7) && (bus.alu_funct3 === hold_m.f3) &&
             (bus.alu_rd === hold_m.rd) && (bus.alu_rs1 === hold_m.a) && (bus.alu_rs2 === hold_m.b);
        n_cmp++;
        if (!ok) begin
          n_fail++;
          $display("FAIL idle_hold cyc=%0d got v=%b ill=%b f7=%h f3=%h rd=%0d rs1=%h rs2=%h exp v=0 ill=0 f7=%h f3=%h rd=%0d rs1=%h rs2=%h",
                   cyc, bus.alu_valid, bus.illegal, bus.alu_funct7, bus.alu_funct3, bus.alu_rd,
                   bus.alu_rs1, bus.alu_rs2, hold_m.f7, hold_m.f3, hold_m.rd, hold_m.a, hold_m.b);
        end
      end
    end
  end

  // ---------------------------------------------------------------- random instr
  function automatic logic [31:0] rand_instr();
    int         k;
    logic [6:0] f7;
    logic [2:0] f3;
    logic [4:0] rd, r1, r2;
    k  = $urandom_range(0, 99);
    if (k < 12) return $urandom();
    rd = 5'($urandom_range(0, 7));
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    f3 = 3'($urandom_range(0, 7));
    f7 = 7'h00;
    if (k >= 70 && k < 90) begin
      f7 = 7'h20;
      f3 = ($urandom_range(0, 1) != 0) ? 3'd0 : 3'd5;
    end else if (k >= 90) begin
      f7 = 7'h20;
    end
    return {f7, r2, r1, f3, rd, 7'h33};
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin : driver
    bit          r;
    bit          held;
    bit          cur_v;
    logic [31:0] cur_i;
    int          pick [$];
    bit          wv;
    logic [4:0]  wrd;

    bus.instr_valid = 0; bus.instr = 0; bus.wb_valid = 0; bus.wb_rd = 0; bus.wb_value = 0;
    hold_m = '{default: 0};
    for (int i = 0; i < 32; i++) begin regs_m[i] = 0; pend_m[i] = 0; end

    step(0, 0, 0, 0, 0, 0, r);
    step(0, 0, 0, 0, 0, 0, r);
    mon_en = 1'b1;

    // add x3,x1,x2 with x1=5, x2=7
    wb(1, 32'd5);
    wb(2, 32'd7);
    issue(32'h002081B3);
    // add x4,x3,x3 stalls until x3 is written back, bypass supplies 12
    issue(32'h00318233);
    issue(32'h00318233);
    step(1, 1, 32'h00318233, 1, 3, 32'd12, r);
    // sub, then f7=0x20 with f3=1 is illegal
    issue(32'h40208133);
    issue(32'h40209133);
    // addi opcode is illegal
    issue(32'h00000013);
    // all-x0 op, then writeback to x0 must be ignored
    issue(32'h00000033);
    wb(0, 32'hFFFFFFFF);
    issue(32'h000003B3);
    drain();
    // set-wins on x5, then reset during a stall on x5
    issue(32'h002082B3);
    step(1, 1, 32'h002082B3, 1, 5, 32'hDEAD0005, r);
    issue(32'h00028333);
    step(0, 1, 32'h00028333, 0, 0, 0, r);
    issue(32'h00028333);
    issue(32'h002081B3);
    drain();

    // randomized traffic
    held  = 0;
    cur_v = 0;
    cur_i = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!held) begin
        cur_v = ($urandom_range(0, 99) < 70);
        cur_i = rand_instr();
      end
      wv  = 0;
      wrd = 0;
      if ($urandom_range(0, 99) < 40) begin
        wv = 1;
        pick.delete();
        for (int i = 1; i < 32; i++) if (pend_m[i]) pick.push_back(i);
        if (pick.size() > 0 && $urandom_range(0, 3) != 0)
          wrd = 5'(pick[$urandom_range(0, pick.size() - 1)]);
        else
          wrd = 5'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 299) == 0) begin
        step(0, cur_v, cur_i, wv, wrd, $urandom(), r);
        held = 0;
      end else begin
        step(1, cur_v, cur_i, wv, wrd, $urandom(), r);
        held = cur_v && !r;
      end
    end

    drain();
    issue(32'h0);
    step(1, 0, 0, 0, 0, 0, r);
    step(1, 0, 0, 0, 0, 0, r);
    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got=%0d entries exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/issue_0110011.md
Name: issue_0110011

Overview:
- Operand-issue stage that sits directly upstream of the R-type ALU (opcode 0110011).
- Accepts 32-bit instructions over a valid/ready handshake and decodes them.
- Reads a 32x32 integer register file, then presents funct7/funct3/rs1/rs2 values to the ALU on a registered one-cycle issue pulse.
- Owns the register-file write port for writeback, plus a per-register pending scoreboard that stalls RAW/WAW hazards.

Parameters:
- XLEN, 32, data width of register file and operands.
- NREGS, 32, number of architectural registers; x0 is hardwired zero.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  synchronous reset, active-low.
- instr_valid  in  1  instr holds a valid instruction.
- instr  in  32  RISC-V instruction word.
- instr_ready  out  1  stage accepts instr this cycle.
- alu_valid  out  1  one-cycle pulse: ALU inputs below are a new op.
- alu_funct7  out  7  instr[31:25] of the issued op.
- alu_funct3  out  3  instr[14:12] of the issued op.
- alu_rs1  out  XLEN  rs1 operand value.
- alu_rs2  out  XLEN  rs2 operand value.
- alu_rd  out  5  destination register of the issued op.
- illegal  out  1  one-cycle pulse: an accepted instruction was rejected.
- wb_valid  in  1  writeback request.
- wb_rd  in  5  writeback destination.
- wb_value  in  XLEN  writeback data.

Behaviour:
- Reset (rst_n low at posedge): all regfile entries = 0, all pending bits = 0, alu_* = 0, alu_valid = 0, illegal = 0. instr_ready = 0 while rst_n is low.
- Decode: opcode = instr[6:0], rd = [11:7], f3 = [14:12], rs1 = [19:15], rs2 = [24:20], f7 = [31:25].
- Legal if and only if opcode == 0110011 and (f7 == 0000000, or f7 == 0100000 with f3 ∈ {0, 5}). Everything else is illegal.
- Hazard (combinational): pend[rs1] | pend[rs2] | pend[rd], each ignored for index 0.
  - A pending bit being cleared by wb_valid in the same cycle counts as not pending.
  - Illegal instructions never stall.
- instr_ready = rst_n & !(legal & hazard). Accept = instr_valid & instr_ready.
- Accept of a legal op: on the next posedge, alu_valid = 1 and alu_funct7/alu_funct3/alu_rd/alu_rs1/alu_rs2 are loaded. If rd != 0, pend[rd] is set.
- Accept of an illegal op: on the next posedge, illegal = 1 and alu_valid = 0. Scoreboard and alu_* fields are unchanged.
- Both alu_valid and illegal fall to 0 on the cycle after their pulse. alu_* data fields hold their values until the next issue.
- Operand read, same cycle as accept:
  - Index 0 reads 0.
  - Else, if wb_valid & wb_rd == index & wb_rd != 0, read wb_value (bypass).
  - Else read regfile[index].
- Writeback: wb_valid & wb_rd != 0 writes regfile[wb_rd] = wb_value and clears pend[wb_rd]. Writes to x0 are ignored. A writeback to a non-pending register is still performed.
- Same-cycle set and clear on one index (issue rd == wb_rd): the set wins, so pend stays 1.
- Throughput is one issue per cycle with no hazards. A stalled instruction issues on the posedge after the clearing writeback's cycle.
- Back-pressure: upstream must hold instr stable while instr_valid & !instr_ready. The stage issues no bubble on its own.
- rst_n low mid-stall: the pending instruction is dropped and the state is fully reset as above.

Test Plan:
- Reset, then wb x1=5 and x2=7, then issue 0x002081B3 (add x3,x1,x2) → next cycle alu_valid=1, rs1=5, rs2=7, f7=0, f3=0, rd=3, pend[3]=1.
- Back-to-back 0x002081B3 then 0x00318233 (add x4,x3,x3) → second stalls (instr_ready=0) until wb x3=12. In the wb cycle instr_ready=1 and the bypass gives rs1=rs2=12.
- Issue 0x40208133 (sub x2,x1,x2) → alu_funct7=0x20. Issue 0x40209133 (f7=0x20, f3=1) → illegal pulse, alu_valid stays 0, no pend change.
- Issue 0x00000013 (addi, opcode 0010011) → illegal=1 for one cycle, instr_ready stayed 1.
- Instruction with rs1=rs2=rd=0 (0x00000033) → issues; operands 0, pend[0] never set. wb to x0 with value 0xFFFFFFFF → x0 still reads 0.
- Issue add x5,… while wb x5 same cycle with x5 pending → pend[5] remains 1. Assert rst_n=0 during a subsequent stall → alu_valid=0, all pend=0, regfile x5 reads 0.
